// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequence buffer.
package simon_pkg;

  localparam int unsigned SEQ_DEPTH = 32;

  // One stored step: codes 0..3 map to buttons 1..4.
  typedef logic [1:0] color_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAppend = 2'd1,
    StPlay   = 2'd2,
    StCheck  = 2'd3
  } state_t;

endpackage

// File: rtl/controls_if.sv
// Random-step source handshake: value is meaningful while ready is high.
interface controls_if;
  import simon_pkg::*;

  logic   ready;
  color_t value;

  modport consumer (input ready, input value);
  modport producer (output ready, output value);

endinterface

// File: rtl/sequence_mem.sv
// DEPTH x 2-bit register file: one synchronous write port, one combinational read port.
module sequence_mem
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH = SEQ_DEPTH,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  color_t        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output color_t        o_rdata
);

  color_t r_mem [DEPTH];

  // Storage write; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sequence_buffer.sv
// Stores a Simon step sequence, replays it to a display and checks player input against it.
module sequence_buffer
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH = SEQ_DEPTH,
  parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  controls_if.consumer     rng,
  input  logic             clear,
  input  logic             append_req,
  input  logic             play_req,
  input  logic             check_req,
  output logic             play_valid,
  output logic [1:0]       play_value,
  input  logic             play_ready,
  input  logic             btn_valid,
  input  logic [1:0]       btn_value,
  output logic             append_done,
  output logic             play_done,
  output logic             check_ok,
  output logic             check_fail,
  output logic             busy,
  output logic [LW-1:0]    length,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_index, w_index_next;
  logic [LW-1:0] r_length, w_length_next;
  logic          r_play_valid, w_play_valid_next;
  color_t        r_play_value, w_play_value_next;
  logic          r_append_done, w_append_done_next;
  logic          r_play_done, w_play_done_next;
  logic          r_check_ok, w_check_ok_next;
  logic          r_check_fail, w_check_fail_next;
  logic          r_busy;
  logic          r_full;

  logic          w_we;
  logic [AW-1:0] w_rd_addr;
  color_t        w_rd_data;
  logic          w_last;

  // PLAY prefetches the next beat so play_value can be registered; CHECK reads the current index.
  always_comb begin
    unique case (r_state)
      StPlay:  w_rd_addr = r_index + AW'(1);
      StCheck: w_rd_addr = r_index;
      default: w_rd_addr = '0;
    endcase
  end

  assign w_last = (LW'(r_index) == (r_length - LW'(1)));

  sequence_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (AW'(r_length)),
    .i_wdata (rng.value),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Next-state logic: clear overrides everything, requests only taken in IDLE.
  always_comb begin
    w_state_next       = r_state;
    w_index_next       = r_index;
    w_length_next      = r_length;
    w_play_valid_next  = r_play_valid;
    w_play_value_next  = r_play_value;
    w_append_done_next = 1'b0;
    w_play_done_next   = 1'b0;
    w_check_ok_next    = 1'b0;
    w_check_fail_next  = 1'b0;
    w_we               = 1'b0;

    if (clear) begin
      w_state_next      = StIdle;
      w_length_next     = '0;
      w_index_next      = '0;
      w_play_valid_next = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (append_req) begin
            // A full buffer swallows the request without a pulse.
            if (!r_full) w_state_next = StAppend;
          end else if (play_req) begin
            if (r_length == '0) begin
              w_play_done_next = 1'b1;
            end else begin
              w_state_next      = StPlay;
              w_index_next      = '0;
              w_play_valid_next = 1'b1;
              w_play_value_next = w_rd_data;
            end
          end else if (check_req) begin
            if (r_length == '0) begin
              w_check_ok_next = 1'b1;
            end else begin
              w_state_next = StCheck;
              w_index_next = '0;
            end
          end
        end
        StAppend: begin
          if (rng.ready) begin
            w_we               = 1'b1;
            w_length_next      = r_length + LW'(1);
            w_append_done_next = 1'b1;
            w_state_next       = StIdle;
          end
        end
        StPlay: begin
          if (play_ready) begin
            if (w_last) begin
              w_play_valid_next = 1'b0;
              w_play_done_next  = 1'b1;
              w_state_next      = StIdle;
            end else begin
              w_index_next      = r_index + AW'(1);
              w_play_value_next = w_rd_data;
            end
          end
        end
        StCheck: begin
          if (btn_valid) begin
            if (btn_value != w_rd_data) begin
              w_check_fail_next = 1'b1;
              w_state_next      = StIdle;
            end else if (w_last) begin
              w_check_ok_next = 1'b1;
              w_state_next    = StIdle;
            end else begin
              w_index_next = r_index + AW'(1);
            end
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // State and registered outputs; busy/full are derived from next-state so they line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_index       <= '0;
      r_length      <= '0;
      r_play_valid  <= 1'b0;
      r_play_value  <= '0;
      r_append_done <= 1'b0;
      r_play_done   <= 1'b0;
      r_check_ok    <= 1'b0;
      r_check_fail  <= 1'b0;
      r_busy        <= 1'b0;
      r_full        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_index       <= w_index_next;
      r_length      <= w_length_next;
      r_play_valid  <= w_play_valid_next;
      r_play_value  <= w_play_value_next;
      r_append_done <= w_append_done_next;
      r_play_done   <= w_play_done_next;
      r_check_ok    <= w_check_ok_next;
      r_check_fail  <= w_check_fail_next;
      r_busy        <= (w_state_next != StIdle);
      r_full        <= (w_length_next == LW'(DEPTH));
    end
  end

  assign play_valid  = r_play_valid;
  assign play_value  = r_play_value;
  assign append_done = r_append_done;
  assign play_done   = r_play_done;
  assign check_ok    = r_check_ok;
  assign check_fail  = r_check_fail;
  assign busy        = r_busy;
  assign length      = r_length;
  assign full        = r_full;

endmodule

// File: doc/sequence_buffer.md
SEQUENCE_BUFFER -- requirements
Module: sequence_buffer

Interface
REQ-001 Parameter DEPTH, default 32, max stored sequence steps; LW = $clog2(DEPTH+1).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rng  controls_if.consumer  -  random-step source; rng.ready high = rng.value (2 bits, codes 0..3 = buttons 1..4) valid.
REQ-005 clear  input  1  synchronous clear of the stored sequence and abort of any operation.
REQ-006 append_req  input  1  one-cycle request to add one rng step.
REQ-007 play_req  input  1  one-cycle request to replay the stored sequence.
REQ-008 check_req  input  1  one-cycle request to compare player input against the sequence.
REQ-009 play_valid  output  1  play_value is presented.
REQ-010 play_value  output  2  current replayed step.
REQ-011 play_ready  input  1  downstream display accepts the step.
REQ-012 btn_valid  input  1  one-cycle player button strobe; btn_value  input  2  pressed button code.
REQ-013 append_done, play_done, check_ok, check_fail  output  1 each  one-cycle completion pulses.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 length  output  LW  number of stored steps; full  output  1  length == DEPTH.

Function
REQ-016 FSM states IDLE, APPEND, PLAY, CHECK; all outputs registered.
REQ-017 Requests are accepted only in IDLE; requests in other states are ignored.
REQ-018 Simultaneous requests in IDLE: priority clear > append_req > play_req > check_req.
REQ-019 append_req with full=0: IDLE->APPEND; with full=1: ignored, no pulse.
REQ-020 APPEND: on the first edge with rng.ready=1, write rng.value to entry[length], length+1, append_done=1 next cycle, ->IDLE; wait indefinitely while rng.ready=0.
REQ-021 play_req with length=0: play_done pulses next cycle, play_valid never asserts, stays IDLE.
REQ-022 PLAY: index starts at 0; play_valid=1, play_value=entry[index], held stable until play_ready=1.
REQ-023 PLAY handshake (play_valid & play_ready) advances index; after the handshake on entry[length-1], play_valid=0 and play_done=1 next cycle, ->IDLE.
REQ-024 check_req with length=0: check_ok pulses next cycle, stays IDLE.
REQ-025 CHECK: each btn_valid compares btn_value to entry[index]; mismatch -> check_fail=1 next cycle, ->IDLE.
REQ-026 CHECK: match on index length-1 -> check_ok=1 next cycle, ->IDLE; other matches advance index, no pulse.
REQ-027 btn_valid outside CHECK is ignored.
REQ-028 clear in any state: length=0, index=0, play_valid=0, ->IDLE next cycle, no completion pulse for the aborted operation.
REQ-029 Stored entries beyond length are don't-care; length never exceeds DEPTH and never wraps.

Reset
REQ-030 rst_n low asynchronously forces: state=IDLE, length=0, index=0, play_valid=0, play_value=0, all pulses=0, busy=0, full=0.
REQ-031 Entry storage is not required to reset.
REQ-032 Reset mid-operation aborts it; no pulse after rst_n release.

Structure
REQ-033 Shared package simon_pkg holds: state enum type, color_t (2-bit) typedef, SEQ_DEPTH default constant.
REQ-034 One sub-module sequence_mem: DEPTH x 2-bit register file, one synchronous write port, one combinational read port.

Verification
REQ-035 Reset, append_req x3 with rng.ready pulsed carrying 2,0,3 -> three append_done pulses, length=3.
REQ-036 play_req, play_ready held low 5 cycles then high -> play_value=2 stable while stalled, beats 2,0,3, then play_done once.
REQ-037 check_req, btn_value 2,0,3 -> check_ok one cycle after third strobe; repeat with 2,1 -> check_fail one cycle after second strobe.
REQ-038 Fill to DEPTH=32 -> full=1; further append_req -> no append_done, length stays 32.
REQ-039 clear asserted mid-PLAY with same-cycle play_req -> play_valid=0, length=0, busy=0 next cycle, no play_done.
REQ-040 rst_n low during APPEND awaiting rng.ready -> outputs at reset values immediately; no append_done after release.
